riscv_run_ctrl: RTL and testbench
=================================

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- XLEN, 32, PC/result width
- NUM_BP, 2, breakpoint comparator count (1..8)
- CNT_W, 32, counter width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_in  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- preset  in  1  synchronous restart request
- run_req  in  1  start/resume free-running
- step_req  in  1  execute exactly one instruction
- halt_req  in  1  external stop
- hlt_in  in  1  halt flag from control unit
- pc  in  XLEN  PC of instruction about to commit
- result_in  in  XLEN  datapath result
- bp_addr  in  NUM_BP*XLEN  breakpoint addresses, slot i at [i*XLEN +: XLEN]
- bp_en  in  NUM_BP  per-slot enable
- core_en  out  1  datapath commit enable this cycle
- core_preset  out  1  one-cycle PC reload pulse to datapath
- state  out  2  FSM state
- halt_cause  out  3  reason for last halt
- bp_idx  out  3  slot that caused the BP halt
- cycle_count  out  CNT_W  cycles spent in RUN/STEP
- instret_count  out  CNT_W  committed instructions
- result_q  out  XLEN  result of last committed instruction

Function
REQ-003 SHALL implement states IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-004 Command priority SHALL be preset > halt_req > run_req > step_req.
REQ-005 preset in any state SHALL:
- assert core_preset for exactly one cycle
- clear both counters, result_q, halt_cause and bp_idx
- move to IDLE
REQ-006 In IDLE or HALTED, run_req SHALL move to RUN and step_req to STEP, unless the sticky halt is set (REQ-013).
REQ-007 bp_hit SHALL be true when any slot i has bp_en[i]=1 and bp_addr slot i equals pc. bp_idx SHALL be the lowest matching i.
REQ-008 In RUN, stop_now = halt_req | hlt_in | (bp_hit & ~bp_skip). core_en SHALL be the combinational value ~stop_now.
REQ-009 In RUN, a cycle with stop_now=1 SHALL:
- move to HALTED with core_en=0, so the stopping instruction is not committed
- set halt_cause to REQ=1, HLT=2 or BP=3, with priority REQ > HLT > BP
REQ-010 bp_skip SHALL be set on any transition into RUN and cleared after the first RUN cycle. This guarantees a resume from a breakpoint commits that instruction.
REQ-011 In STEP, core_en SHALL be 1 for one cycle regardless of bp_hit, then the block moves to HALTED with halt_cause=STEP=4. If hlt_in=1 or halt_req=1 in that cycle, core_en SHALL be 0 and the matching cause is recorded instead.
REQ-012 core_en SHALL be 0 in IDLE and HALTED.
REQ-013 A halt with cause HLT SHALL be sticky: run_req and step_req are ignored until preset.
REQ-014 cycle_count SHALL increment every cycle state is RUN or STEP. instret_count SHALL increment every cycle core_en=1. Both SHALL wrap modulo 2^CNT_W.
REQ-015 result_q SHALL register result_in on every cycle core_en=1 and hold its value otherwise.
REQ-016 Inputs SHALL be treated as synchronous, level-sensitive and sampled every cycle. No edge detection is performed.

Reset
REQ-017 rst=0 SHALL asynchronously force:
- state to IDLE
- core_en=0, core_preset=0
- halt_cause=0, bp_idx=0, bp_skip=0, sticky halt clear
- both counters, result_q and all other registers to 0
REQ-018 Deassertion of rst SHALL NOT by itself generate core_preset.

Structure
REQ-019 State encodings and halt_cause codes (NONE=0, REQ=1, HLT=2, BP=3, STEP=4) SHALL live in the shared package riscv_pkg.
REQ-020 The comparator array SHALL be one sub-module, riscv_bp_match, taking NUM_BP and XLEN and producing hit and idx combinationally.
REQ-021 riscv_run_ctrl SHALL contain only the FSM, counters and result register. No clock gating is allowed; core_en is a clock enable.

Verification
REQ-022 Reset, then run_req=1 for one cycle with pc stepping 0,4,8…, then halt_req at pc=0x10:
- state HALTED, halt_cause=1
- instret_count=4, cycle_count=5
REQ-023 bp_addr[0]=0x8, bp_en=01, run_req:
- halt at pc=0x8 with cause=3, bp_idx=0, instret_count=2
- then run_req: 0x8 commits and the run continues
REQ-024 From IDLE, step_req three times with gaps:
- each step gives exactly one core_en pulse
- instret_count=3, halt_cause=4 after each step
- result_q equals result_in sampled at the third pulse
REQ-025 hlt_in=1 during RUN:
- HALTED with cause=2
- later run_req and step_req are ignored
- preset gives a core_preset pulse, state IDLE and counters 0
REQ-026 preset and halt_req asserted in the same RUN cycle: preset wins, with core_preset=1 and state IDLE.
REQ-027 rst asserted low mid-RUN: all outputs go to 0 immediately without waiting for a clk_in edge. CNT_W=4 run of 20 cycles: cycle_count wraps to 4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the run-control slice: FSM states, halt causes and
// the width of the breakpoint slot index.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_REQ  = 3'd1,
        CAUSE_HLT  = 3'd2,
        CAUSE_BP   = 3'd3,
        CAUSE_STEP = 3'd4
    } halt_cause_e;

    localparam int BP_IDX_W = 3;

    // True while the core is allowed to execute (free-running or single step)
    function automatic logic is_active(input run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/riscv_bp_match.sv
// Breakpoint comparator array: flags a hit when any enabled slot holds the
// current PC and reports the lowest-numbered matching slot.
module riscv_bp_match
    import riscv_pkg::*;
#(
    parameter int NUM_BP = 2,
    parameter int XLEN   = 32
) (
    input  logic [XLEN-1:0]        pc_i,
    input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    output logic                   hit_o,
    output logic [BP_IDX_W-1:0]    idx_o
);

    // Scan from the top slot down so the lowest matching slot is written last
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_i[i] && (bp_addr_i[i*XLEN +: XLEN] == pc_i)) begin
                hit_o = 1'b1;
                idx_o = BP_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run/step/halt controller for a small RISC-V core: decides each cycle
// whether the datapath may commit, tracks why the core last stopped, and
// keeps cycle/retired-instruction counters plus the last committed result.
module riscv_run_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 32
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   preset,
    input  logic                   run_req,
    input  logic                   step_req,
    input  logic                   halt_req,
    input  logic                   hlt_in,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        result_in,
    input  logic [NUM_BP*XLEN-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   core_en,
    output logic                   core_preset,
    output logic [1:0]             state,
    output logic [2:0]             halt_cause,
    output logic [2:0]             bp_idx,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       instret_count,
    output logic [XLEN-1:0]        result_q
);

    run_state_e            state_q, state_d;
    halt_cause_e           cause_q, cause_d;
    logic [BP_IDX_W-1:0]   bp_idx_q, bp_idx_d;
    logic                  bp_skip_q, bp_skip_d;
    logic                  sticky_q, sticky_d;
    logic                  core_preset_q;
    logic [CNT_W-1:0]      cycle_q;
    logic [CNT_W-1:0]      instret_q;
    logic [XLEN-1:0]       res_q;

    logic                  bp_hit;
    logic [BP_IDX_W-1:0]   bp_match_idx;
    logic                  stop_now;
    logic                  step_stop;

    riscv_bp_match #(
        .NUM_BP (NUM_BP),
        .XLEN   (XLEN)
    ) u_bp_match (
        .pc_i      (pc),
        .bp_addr_i (bp_addr),
        .bp_en_i   (bp_en),
        .hit_o     (bp_hit),
        .idx_o     (bp_match_idx)
    );

    // The breakpoint is masked on the first RUN cycle so a resume can commit
    // the very instruction that tripped it.
    assign stop_now  = halt_req | hlt_in | (bp_hit & ~bp_skip_q);
    assign step_stop = halt_req | hlt_in;

    // FSM and halt-status registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            bp_idx_q  <= '0;
            bp_skip_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            bp_idx_q  <= bp_idx_d;
            bp_skip_q <= bp_skip_d;
            sticky_q  <= sticky_d;
        end
    end

    // Next state: preset beats everything, then halt_req, run_req, step_req
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        bp_idx_d = bp_idx_q;
        sticky_d = sticky_q;
        if (preset) begin
            state_d  = ST_IDLE;
            cause_d  = CAUSE_NONE;
            bp_idx_d = '0;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (!halt_req && !sticky_q) begin
                        if (run_req) begin
                            state_d = ST_RUN;
                        end else if (step_req) begin
                            state_d = ST_STEP;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop_now) begin
                        state_d = ST_HALTED;
                        if (halt_req) begin
                            cause_d = CAUSE_REQ;
                        end else if (hlt_in) begin
                            cause_d  = CAUSE_HLT;
                            sticky_d = 1'b1;
                        end else begin
                            cause_d  = CAUSE_BP;
                            bp_idx_d = bp_match_idx;
                        end
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALTED;
                    if (halt_req) begin
                        cause_d = CAUSE_REQ;
                    end else if (hlt_in) begin
                        cause_d  = CAUSE_HLT;
                        sticky_d = 1'b1;
                    end else begin
                        cause_d = CAUSE_STEP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        bp_skip_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // Commit enable; a restart cycle never commits since the PC is being reloaded
    always_comb begin
        core_en = 1'b0;
        if (!preset) begin
            case (state_q)
                ST_RUN:  core_en = ~stop_now;
                ST_STEP: core_en = ~step_stop;
                default: core_en = 1'b0;
            endcase
        end
    end

    // Counters, last committed result and the PC-reload pulse
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cycle_q       <= '0;
            instret_q     <= '0;
            res_q         <= '0;
            core_preset_q <= 1'b0;
        end else begin
            core_preset_q <= preset;
            if (preset) begin
                cycle_q   <= '0;
                instret_q <= '0;
                res_q     <= '0;
            end else begin
                if (is_active(state_q)) begin
                    cycle_q <= cycle_q + 1'b1;
                end
                if (core_en) begin
                    instret_q <= instret_q + 1'b1;
                    res_q     <= result_in;
                end
            end
        end
    end

    assign core_preset   = core_preset_q;
    assign state         = state_q;
    assign halt_cause    = cause_q;
    assign bp_idx        = bp_idx_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
    assign result_q      = res_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: directed scenarios with fixed
// expectations, then a randomized stretch compared every cycle against a
// behavioural model of the run-control rules.
module tb_riscv_run_ctrl;

    localparam int XLEN   = 32;
    localparam int NUM_BP = 2;

    logic                   clk_in = 1'b0;
    logic                   rst;
    logic                   preset, run_req, step_req, halt_req, hlt_in;
    logic [XLEN-1:0]        pc, result_in;
    logic [NUM_BP*XLEN-1:0] bp_addr;
    logic [NUM_BP-1:0]      bp_en;

    logic                   core_en, core_preset;
    logic [1:0]             state;
    logic [2:0]             halt_cause, bp_idx;
    logic [31:0]            cycle_count, instret_count;
    logic [XLEN-1:0]        result_q;

    logic                   core_en4, core_preset4;
    logic [1:0]             state4;
    logic [2:0]             halt_cause4, bp_idx4;
    logic [3:0]             cycle_count4, instret_count4;
    logic [XLEN-1:0]        result_q4;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 idle, 1 run, 2 step, 3 halted
    int          mState;
    int          mCause;
    int          mBpIdx;
    bit          mSticky;
    bit          mJustResumed;
    logic [63:0] mCycles;
    logic [63:0] mInstret;
    logic [31:0] mResult;
    bit          mPresetPulse;

    bit          autoPc;
    bit          expEn;
    int          enPulses;
    logic        lastEnObs;
    logic [31:0] lastResult;

    riscv_run_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(32)) dut (
        .clk_in(clk_in), .rst(rst), .preset(preset), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .hlt_in(hlt_in), .pc(pc),
        .result_in(result_in), .bp_addr(bp_addr), .bp_en(bp_en),
        .core_en(core_en), .core_preset(core_preset), .state(state),
        .halt_cause(halt_cause), .bp_idx(bp_idx), .cycle_count(cycle_count),
        .instret_count(instret_count), .result_q(result_q)
    );

    riscv_run_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(4)) dut4 (
        .clk_in(clk_in), .rst(rst), .preset(preset), .run_req(run_req),
        .step_req(step_req), .halt_req(halt_req), .hlt_in(hlt_in), .pc(pc),
        .result_in(result_in), .bp_addr(bp_addr), .bp_en(bp_en),
        .core_en(core_en4), .core_preset(core_preset4), .state(state4),
        .halt_cause(halt_cause4), .bp_idx(bp_idx4), .cycle_count(cycle_count4),
        .instret_count(instret_count4), .result_q(result_q4)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest enabled slot whose address equals the current PC
    function automatic bit modelBpHit(output int idx);
        idx = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_addr[i*XLEN +: XLEN] == pc)) begin
                idx = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Does the instruction at pc commit this cycle?
    function automatic bit modelCoreEn();
        int  idx;
        bit  hit;
        hit = modelBpHit(idx);
        if (preset) return 1'b0;
        if (mState == 1) return !(halt_req || hlt_in || (hit && !mJustResumed));
        if (mState == 2) return !(halt_req || hlt_in);
        return 1'b0;
    endfunction

    task automatic modelReset();
        mState = 0; mCause = 0; mBpIdx = 0; mSticky = 0; mJustResumed = 0;
        mCycles = 0; mInstret = 0; mResult = 0; mPresetPulse = 0;
    endtask

    // Apply the rules of one clock edge to the model
    task automatic modelAdvance();
        bit en;
        bit hit;
        int hitIdx;
        int nextState;
        en  = modelCoreEn();
        hit = modelBpHit(hitIdx);
        if (preset) begin
            modelReset();
            mPresetPulse = 1;
        end else begin
            mPresetPulse = 0;
            if (mState == 1 || mState == 2) mCycles = mCycles + 1;
            if (en) begin
                mInstret = mInstret + 1;
                mResult  = result_in;
            end
            nextState = mState;
            if (mState == 0 || mState == 3) begin
                if (!halt_req && !mSticky) begin
                    if (run_req) nextState = 1;
                    else if (step_req) nextState = 2;
                end
            end else if (mState == 1) begin
                if (halt_req) begin nextState = 3; mCause = 1; end
                else if (hlt_in) begin nextState = 3; mCause = 2; mSticky = 1; end
                else if (hit && !mJustResumed) begin nextState = 3; mCause = 3; mBpIdx = hitIdx; end
            end else begin
                nextState = 3;
                if (halt_req) mCause = 1;
                else if (hlt_in) begin mCause = 2; mSticky = 1; end
                else mCause = 4;
            end
            mJustResumed = (nextState == 1) && (mState != 1);
            mState = nextState;
        end
    endtask

    task automatic compareAll();
        checkOutput("state", state, mState);
        checkOutput("halt_cause", halt_cause, mCause);
        checkOutput("bp_idx", bp_idx, mBpIdx);
        checkOutput("core_preset", core_preset, mPresetPulse);
        checkOutput("cycle_count", cycle_count, mCycles[31:0]);
        checkOutput("instret_count", instret_count, mInstret[31:0]);
        checkOutput("result_q", result_q, mResult);
        checkOutput("state_w4", state4, mState);
        checkOutput("cycle_count_w4", cycle_count4, mCycles[3:0]);
        checkOutput("instret_count_w4", instret_count4, mInstret[3:0]);
    endtask

    // One clock: inputs are already driven just after a negedge
    task automatic applyStimulus();
        #1;
        expEn = modelCoreEn();
        lastEnObs = core_en;
        if (core_en === 1'b1) enPulses++;
        checkOutput("core_en", core_en, expEn);
        @(posedge clk_in);
        modelAdvance();
        @(negedge clk_in);
        if (preset) pc = '0;
        else if (autoPc && expEn) pc = pc + 32'd4;
        compareAll();
    endtask

    task automatic clearCmds();
        preset = 0; run_req = 0; step_req = 0; halt_req = 0; hlt_in = 0;
    endtask

    task automatic doPreset();
        preset = 1;
        applyStimulus();
        preset = 0;
    endtask

    initial begin
        clearCmds();
        rst = 1; pc = '0; result_in = '0; bp_addr = '0; bp_en = '0;
        autoPc = 1; enPulses = 0;
        modelReset();
        #2 rst = 0;
        @(negedge clk_in);
        #1;
        checkOutput("reset state", state, 0);
        checkOutput("reset core_en", core_en, 0);
        checkOutput("reset core_preset", core_preset, 0);
        checkOutput("reset cycle", cycle_count, 0);
        checkOutput("reset result", result_q, 0);
        rst = 1;
        applyStimulus();
        checkOutput("no preset after reset", core_preset, 0);

        // Run then halt_req at pc 0x10
        result_in = 32'h1234_5678;
        run_req = 1; applyStimulus(); run_req = 0;
        repeat (4) applyStimulus();
        halt_req = 1; applyStimulus(); halt_req = 0;
        checkOutput("req halt state", state, 3);
        checkOutput("req halt cause", halt_cause, 1);
        checkOutput("req halt instret", instret_count, 4);
        checkOutput("req halt cycles", cycle_count, 5);

        // Breakpoint at 0x8, then resume through it and stop on slot 1 at 0x10
        doPreset();
        bp_addr = {32'h0, 32'h8}; bp_en = 2'b01;
        run_req = 1; applyStimulus(); run_req = 0;
        repeat (3) applyStimulus();
        checkOutput("bp halt state", state, 3);
        checkOutput("bp halt cause", halt_cause, 3);
        checkOutput("bp halt idx", bp_idx, 0);
        checkOutput("bp halt instret", instret_count, 2);
        bp_addr = {32'h10, 32'h8}; bp_en = 2'b11;
        run_req = 1; applyStimulus(); run_req = 0;
        applyStimulus();
        checkOutput("bp resume commits", lastEnObs, 1);
        checkOutput("bp resume instret", instret_count, 3);
        applyStimulus();
        applyStimulus();
        checkOutput("bp slot1 cause", halt_cause, 3);
        checkOutput("bp slot1 idx", bp_idx, 1);
        checkOutput("bp slot1 instret", instret_count, 4);

        // Three single steps with gaps, breakpoint armed on the stepped pc
        doPreset();
        for (int k = 1; k <= 3; k++) begin
            enPulses = 0;
            step_req = 1; applyStimulus(); step_req = 0;
            bp_addr = {32'h0, pc}; bp_en = 2'b01;
            result_in = $urandom();
            lastResult = result_in;
            repeat (3) applyStimulus();
            checkOutput("step pulses", enPulses, 1);
            checkOutput("step cause", halt_cause, 4);
            checkOutput("step instret", instret_count, k);
        end
        checkOutput("step result", result_q, lastResult);
        bp_en = 2'b00;

        // Sticky hlt_in halt, only preset recovers
        doPreset();
        run_req = 1; applyStimulus(); run_req = 0;
        repeat (2) applyStimulus();
        hlt_in = 1; applyStimulus(); hlt_in = 0;
        checkOutput("hlt state", state, 3);
        checkOutput("hlt cause", halt_cause, 2);
        run_req = 1; applyStimulus(); run_req = 0;
        step_req = 1; applyStimulus(); step_req = 0;
        applyStimulus();
        checkOutput("sticky state", state, 3);
        checkOutput("sticky instret", instret_count, 2);
        doPreset();
        checkOutput("sticky preset pulse", core_preset, 1);
        checkOutput("sticky preset state", state, 0);
        checkOutput("sticky preset cycles", cycle_count, 0);
        applyStimulus();
        checkOutput("preset pulse width", core_preset, 0);

        // preset and halt_req together mid-run
        run_req = 1; applyStimulus(); run_req = 0;
        applyStimulus();
        preset = 1; halt_req = 1; applyStimulus(); clearCmds();
        checkOutput("preset wins pulse", core_preset, 1);
        checkOutput("preset wins state", state, 0);
        checkOutput("preset wins cause", halt_cause, 0);

        // Randomized commands and breakpoints against the model
        autoPc = 0;
        for (int n = 0; n < 600; n++) begin
            preset    = ($urandom_range(0, 99) < 3);
            halt_req  = ($urandom_range(0, 99) < 8);
            hlt_in    = ($urandom_range(0, 99) < 4);
            run_req   = ($urandom_range(0, 99) < 20);
            step_req  = ($urandom_range(0, 99) < 15);
            pc        = $urandom_range(0, 7) * 4;
            result_in = $urandom();
            if ((n % 25) == 0) begin
                bp_addr[31:0]  = $urandom_range(0, 7) * 4;
                bp_addr[63:32] = $urandom_range(0, 7) * 4;
                bp_en          = 2'($urandom_range(0, 3));
            end
            applyStimulus();
        end
        clearCmds();
        autoPc = 1; pc = '0; bp_en = 2'b00;

        // 20 RUN cycles: narrow counter wraps, then async reset mid-run
        doPreset();
        run_req = 1; applyStimulus(); run_req = 0;
        repeat (20) applyStimulus();
        checkOutput("wrap cycle w4", cycle_count4, 4);
        checkOutput("wrap cycle w32", cycle_count, 20);
        #2 rst = 0;
        #1;
        checkOutput("async state", state, 0);
        checkOutput("async core_en", core_en, 0);
        checkOutput("async core_preset", core_preset, 0);
        checkOutput("async cause", halt_cause, 0);
        checkOutput("async bp_idx", bp_idx, 0);
        checkOutput("async cycle", cycle_count, 0);
        checkOutput("async instret", instret_count, 0);
        checkOutput("async result", result_q, 0);
        checkOutput("async cycle w4", cycle_count4, 0);
        modelReset();
        pc = '0;
        @(negedge clk_in);
        rst = 1;
        applyStimulus();
        checkOutput("no preset after async reset", core_preset, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
